shift_issue_stage: RTL and testbench

SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

---
 rtl/shift_issue_stage_pkg.sv | 15 +
 rtl/shift_issue_stage_decode.sv | 27 ++
 rtl/shift_issue_stage.sv | 82 ++++++++
 tb/tb_shift_issue_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/shift_issue_stage_pkg.sv
// shift_issue_stage_pkg: R-type shift funct codes and shifter op encodings,
// shared by the issue stage and the external shifter.
package shift_issue_stage_pkg;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } sh_op_e;
endpackage

// File: rtl/shift_issue_stage_decode.sv
// shift_decode: maps funct to shifter op, selects immediate or register amount,
// and flags non-shift functs as illegal (op and amount forced to zero).
module shift_decode
  import shift_issue_stage_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_amt,
  output sh_op_e     op,
  output logic [4:0] amount,
  output logic       illegal
);
  always_comb begin
    op      = OP_SLL;
    amount  = '0;
    illegal = 1'b0;
    case (funct)
      F_SLL:  amount = shamt;
      F_SRL:  begin op = OP_SRL; amount = shamt; end
      F_SRA:  begin op = OP_SRA; amount = shamt; end
      F_SLLV: amount = rs_amt;
      F_SRLV: begin op = OP_SRL; amount = rs_amt; end
      F_SRAV: begin op = OP_SRA; amount = rs_amt; end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: two-entry pipeline; stage A holds decoded operands driving an
// external shifter, stage B captures the shifter result for writeback.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  rd,
  output logic [31:0] sh_input1,
  output logic [31:0] sh_input2,
  output logic [1:0]  sh_op,
  input  logic [31:0] sh_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);
  sh_op_e      d_op, a_op;
  logic [4:0]  d_amt, a_amt, a_rd;
  logic        d_ill, a_ill, a_valid;
  logic [31:0] a_in1;
  logic        b_can_accept, a_to_b, accept;
  logic        unused_rs;
  assign unused_rs = ^rs_val[31:5];
  shift_decode u_decode (
    .funct   (funct),
    .shamt   (shamt),
    .rs_amt  (rs_val[4:0]),
    .op      (d_op),
    .amount  (d_amt),
    .illegal (d_ill)
  );
  assign b_can_accept = !out_valid || out_ready;
  assign a_to_b       = a_valid && b_can_accept;
  assign in_ready     = !a_valid || b_can_accept;
  assign accept       = in_valid && in_ready;
  // Shifter inputs read as zero whenever stage A is empty.
  assign sh_input1 = a_valid ? a_in1 : '0;
  assign sh_input2 = {27'd0, a_valid ? a_amt : 5'd0};
  assign sh_op     = a_valid ? a_op : OP_SLL;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid <= 1'b0;
      a_in1   <= '0;
      a_amt   <= '0;
      a_op    <= OP_SLL;
      a_rd    <= '0;
      a_ill   <= 1'b0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_in1   <= rt_val;
      a_amt   <= d_amt;
      a_op    <= d_op;
      a_rd    <= rd;
      a_ill   <= d_ill;
    end else if (a_to_b) begin
      a_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (a_to_b) begin
      out_valid   <= 1'b1;
      out_result  <= a_ill ? '0 : sh_result;
      out_rd      <= a_rd;
      out_illegal <= a_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: randomized and directed checks against an occupancy/age
// based reference model of the two-stage shift issue pipeline.
module tb_shift_issue_stage;
  logic        clk, reset_n, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [5:0]  funct;
  logic [4:0]  shamt, rd, out_rd;
  logic [31:0] rs_val, rt_val, sh_input1, sh_input2, sh_result, out_result;
  logic [1:0]  sh_op;

  typedef struct {
    logic [31:0] res;
    logic [31:0] in1;
    logic [4:0]  amt;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        ill;
    int          t;
  } item_t;

  item_t q[$];
  int    total = 0, bad = 0, cyc = 0;
  logic  acc;
  logic [31:0] hold;

  shift_issue_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .rd(rd),
    .sh_input1(sh_input1), .sh_input2(sh_input2), .sh_op(sh_op), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  // External shifter
  always_comb
    sh_result = sh_op == 2'd0 ? sh_input1 << sh_input2 :
                sh_op == 2'd1 ? sh_input1 >> sh_input2 :
                sh_op == 2'd2 ? 32'($signed(sh_input1) >>> sh_input2) : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic item_t mk(input logic [5:0] f, input logic [4:0] sa,
                               input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] r);
    item_t it;
    logic [4:0] v;
    v = rs[4:0];
    it.rd = r; it.in1 = rt; it.ill = 1'b0; it.t = 0;
    case (f)
      6'b000000: begin it.op = 2'd0; it.amt = sa; it.res = rt << sa; end
      6'b000010: begin it.op = 2'd1; it.amt = sa; it.res = rt >> sa; end
      6'b000011: begin it.op = 2'd2; it.amt = sa; it.res = 32'($signed(rt) >>> sa); end
      6'b000100: begin it.op = 2'd0; it.amt = v;  it.res = rt << v; end
      6'b000110: begin it.op = 2'd1; it.amt = v;  it.res = rt >> v; end
      6'b000111: begin it.op = 2'd2; it.amt = v;  it.res = 32'($signed(rt) >>> v); end
      default:   begin it.op = 2'd0; it.amt = 5'd0; it.res = 32'd0; it.ill = 1'b1; end
    endcase
    return it;
  endfunction

  // One clock cycle, starting and ending at a falling edge.
  task automatic step(input logic iv, input logic [5:0] f, input logic [4:0] sa,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] r,
                      input logic ordy, output logic accepted);
    int n;
    logic ov, exp_ir, a_occ;
    item_t it;
    in_valid = iv; funct = f; shamt = sa; rs_val = rs; rt_val = rt; rd = r; out_ready = ordy;
    #1;
    n = q.size();
    ov = n > 0 && (cyc - q[0].t) >= 2;
    exp_ir = n < 2 || ordy;
    a_occ = n == 2 || (n == 1 && (cyc - q[0].t) < 2);
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    if (ov) begin
      chk("out_result", out_result, q[0].res);
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
    if (a_occ) begin
      chk("sh_input1", sh_input1, q[n-1].in1);
      chk("sh_input2", sh_input2, 32'(q[n-1].amt));
      chk("sh_op", 32'(sh_op), 32'(q[n-1].op));
    end else begin
      chk("sh_idle", sh_input1 | sh_input2 | 32'(sh_op), 32'd0);
    end
    if (ov && ordy) void'(q.pop_front());
    accepted = iv && exp_ir;
    if (accepted) begin
      it = mk(f, sa, rs, rt, r);
      it.t = cyc;
      q.push_back(it);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct = '0; shamt = '0; rs_val = '0; rt_val = '0; rd = '0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_sh_input1", sh_input1, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("first_in_ready", 32'(in_ready), 32'd1);

    // sra by 8
    step(1'b1, 6'b000011, 5'd8, 32'd0, 32'h80008000, 5'd3, 1'b1, acc);
    step(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
    chk("sra8_valid", 32'(out_valid), 32'd1);
    chk("sra8_result", out_result, 32'hFF800080);
    idle(1);

    // srav with upper rs bits ignored
    step(1'b1, 6'b000111, 5'd9, 32'h00000035, 32'h81000038, 5'd7, 1'b1, acc);
    chk("srav_amount", sh_input2, 32'h00000015);
    step(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
    chk("srav_result", out_result, 32'hFFFFFC08);
    idle(1);

    // shift by 31, arithmetic then logical, back to back
    step(1'b1, 6'b000011, 5'd31, 32'd0, 32'h80000000, 5'd1, 1'b1, acc);
    step(1'b1, 6'b000010, 5'd31, 32'd0, 32'h80000000, 5'd2, 1'b1, acc);
    chk("sra31_result", out_result, 32'hFFFFFFFF);
    step(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
    chk("srl31_result", out_result, 32'h00000001);
    idle(1);

    // backpressure: three ops with out_ready low for three cycles
    step(1'b1, 6'b000000, 5'd4, 32'd0, 32'h0000000F, 5'd10, 1'b0, acc);
    step(1'b1, 6'b000100, 5'd0, 32'hFFFFFFE1, 32'h00000003, 5'd11, 1'b0, acc);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    hold = out_result;
    step(1'b1, 6'b000110, 5'd0, 32'd2, 32'h00000100, 5'd12, 1'b0, acc);
    chk("bp_third_held", 32'(acc), 32'd0);
    chk("bp_out_stable", out_result, hold);
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++)
      step(1'b1, 6'b000110, 5'd0, 32'd2, 32'h00000100, 5'd12, 1'b1, acc);
    chk("bp_third_taken", 32'(acc), 32'd1);
    idle(3);

    // illegal funct
    step(1'b1, 6'b100000, 5'd5, 32'd3, 32'h12345678, 5'd9, 1'b1, acc);
    step(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_result", out_result, 32'd0);
    idle(1);

    // reset with both stages full
    step(1'b1, 6'b000000, 5'd1, 32'd0, 32'h1, 5'd4, 1'b0, acc);
    step(1'b1, 6'b000000, 5'd2, 32'd0, 32'h1, 5'd5, 1'b0, acc);
    chk("pre_rst_full", 32'(out_valid & ~in_ready), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sh_input1", sh_input1, 32'd0);
    chk("mid_rst_out_rd", 32'(out_rd), 32'd0);
    q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0] f;
      case ($urandom_range(0, 7))
        0: f = 6'b000000; 1: f = 6'b000010; 2: f = 6'b000011; 3: f = 6'b000100;
        4: f = 6'b000110; 5: f = 6'b000111; 6: f = 6'b100000;
        default: f = 6'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, f, 5'($urandom), $urandom, $urandom,
           5'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    idle(4);
    chk("drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
